// File: rtl/eth_tx_pkt_gen.sv
// rtl/eth_tx_pkt_gen.sv - Ethernet test-frame generator feeding the xge_mac pkt_tx interface
// Optional feature macro: ETH_TX_PKT_GEN_PRBS_EN selects a PRBS31 payload instead of the byte ramp.
module eth_tx_pkt_gen #(
   parameter int LEN_W = 14,
   parameter int CNT_W = 32
) (
   input  logic             clk_156,
   input  logic             async_reset,
   input  logic             start,
   input  logic             stop,
   input  logic [LEN_W-1:0] frame_len,
   input  logic [CNT_W-1:0] frame_cnt,
   input  logic [7:0]       ifg_cycles,
   input  logic [47:0]      dst_mac,
   input  logic [47:0]      src_mac,
   input  logic [15:0]      ethertype,
   input  logic             pkt_tx_full,
   output logic [63:0]      pkt_tx_data,
   output logic             pkt_tx_sop,
   output logic             pkt_tx_eop,
   output logic             pkt_tx_val,
   output logic [2:0]       pkt_tx_mod,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] frames_sent
);

   typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

   state_t           r_state, w_next;
   logic [LEN_W-1:0] r_len, r_word_idx, w_last_idx;
   logic [CNT_W-1:0] r_frame_cnt;
   logic [7:0]       r_ifg, r_gap_cnt;
   logic [47:0]      r_dst, r_src;
   logic [15:0]      r_type;
   logic             r_stop_pend;
   logic             w_issue, w_last, w_end_run;
   logic [63:0]      w_word, w_pay;

`ifdef ETH_TX_PKT_GEN_PRBS_EN
   logic [30:0]      r_lfsr, w_lfsr_next;

   // Advance PRBS31 (x^31+x^28+1) by 64 steps; each new feedback bit is the next payload bit, MSB first
   function automatic logic [94:0] prbs31_step64(input logic [30:0] s_in);
      logic [30:0] s;
      logic [63:0] o;
      logic        b;
      s = s_in;
      o = '0;
      for (int i = 63; i >= 0; i--) begin
         b    = s[30] ^ s[27];
         s    = {s[29:0], b};
         o[i] = b;
      end
      return {s, o};
   endfunction
`else
   logic [7:0]       r_pay_byte;
`endif

   // State register
   always_ff @(posedge clk_156 or posedge async_reset) begin
      if (async_reset) r_state <= S_IDLE;
      else             r_state <= w_next;
   end

   // Next-state logic and per-cycle word issue decode
   always_comb begin
      w_next     = r_state;
      w_last_idx = (r_len - LEN_W'(1)) >> 3;
      w_issue    = (r_state == S_SEND) && !pkt_tx_full;
      w_last     = (r_word_idx == w_last_idx);
      w_end_run  = r_stop_pend || stop ||
                   ((r_frame_cnt != '0) && (frames_sent + CNT_W'(1) == r_frame_cnt));
      case (r_state)
         S_IDLE: if (start) w_next = S_SEND;
         S_SEND: begin
            if (w_issue && w_last) begin
               if (w_end_run)        w_next = S_DONE;
               else if (r_ifg != '0) w_next = S_GAP;
               else                  w_next = S_SEND;
            end
         end
         S_GAP: begin
            if (stop || r_stop_pend)     w_next = S_DONE;
            else if (r_gap_cnt <= 8'd1)  w_next = S_SEND;
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Word content: two header words, then generated payload
   always_comb begin
      w_pay = '0;
`ifdef ETH_TX_PKT_GEN_PRBS_EN
      w_lfsr_next = r_lfsr;
      {w_lfsr_next, w_pay} = prbs31_step64(r_lfsr);
`else
      for (int j = 0; j < 8; j++) w_pay[63-8*j -: 8] = r_pay_byte + 8'(j);
`endif
      if (r_word_idx == '0)             w_word = {r_dst, r_src[47:32]};
      else if (r_word_idx == LEN_W'(1)) w_word = {r_src[31:0], r_type, frames_sent[15:0]};
      else                              w_word = w_pay;
   end

   // Run configuration latch, word pointer, counters and registered outputs
   always_ff @(posedge clk_156 or posedge async_reset) begin
      if (async_reset) begin
         pkt_tx_data <= '0; pkt_tx_sop <= 1'b0; pkt_tx_eop <= 1'b0; pkt_tx_val <= 1'b0;
         pkt_tx_mod  <= '0; busy <= 1'b0; done <= 1'b0; frames_sent <= '0;
         r_len <= '0; r_word_idx <= '0; r_frame_cnt <= '0; r_ifg <= '0; r_gap_cnt <= '0;
         r_dst <= '0; r_src <= '0; r_type <= '0; r_stop_pend <= 1'b0;
`ifdef ETH_TX_PKT_GEN_PRBS_EN
         r_lfsr <= '1;
`else
         r_pay_byte <= '0;
`endif
      end else begin
         pkt_tx_val <= 1'b0;
         pkt_tx_sop <= 1'b0;
         pkt_tx_eop <= 1'b0;
         done       <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_len       <= (frame_len < LEN_W'(60)) ? LEN_W'(60) : frame_len;
                  r_frame_cnt <= frame_cnt;
                  r_ifg       <= ifg_cycles;
                  r_dst       <= dst_mac;
                  r_src       <= src_mac;
                  r_type      <= ethertype;
                  r_stop_pend <= stop;
                  r_word_idx  <= '0;
                  frames_sent <= '0;
                  busy        <= 1'b1;
`ifdef ETH_TX_PKT_GEN_PRBS_EN
                  r_lfsr      <= '1;
`else
                  r_pay_byte  <= '0;
`endif
               end
            end
            S_SEND: begin
               if (stop) r_stop_pend <= 1'b1;
               if (w_issue) begin
                  pkt_tx_data <= w_word;
                  pkt_tx_val  <= 1'b1;
                  pkt_tx_sop  <= (r_word_idx == '0);
                  pkt_tx_eop  <= w_last;
                  pkt_tx_mod  <= w_last ? r_len[2:0] : 3'd0;
                  if (w_last) begin
                     frames_sent <= frames_sent + CNT_W'(1);
                     r_word_idx  <= '0;
                     r_gap_cnt   <= r_ifg;
`ifdef ETH_TX_PKT_GEN_PRBS_EN
                     r_lfsr      <= '1;
`else
                     r_pay_byte  <= '0;
`endif
                  end else begin
                     r_word_idx <= r_word_idx + LEN_W'(1);
`ifdef ETH_TX_PKT_GEN_PRBS_EN
                     if (r_word_idx >= LEN_W'(2)) r_lfsr <= w_lfsr_next;
`else
                     if (r_word_idx >= LEN_W'(2)) r_pay_byte <= r_pay_byte + 8'd8;
`endif
                  end
               end
            end
            S_GAP: begin
               if (stop) r_stop_pend <= 1'b1;
               if (r_gap_cnt != '0) r_gap_cnt <= r_gap_cnt - 8'd1;
            end
            S_DONE: begin
               done        <= 1'b1;
               busy        <= 1'b0;
               r_stop_pend <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_eth_tx_pkt_gen.sv
// tb/tb_eth_tx_pkt_gen.sv - self-checking bench for eth_tx_pkt_gen (byte-stream frame model)
module tb_eth_tx_pkt_gen;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0, stop = 1'b0, full = 1'b0;
   logic [13:0] frame_len = '0;
   logic [31:0] frame_cnt = '0;
   logic [7:0]  ifg_cycles = '0;
   logic [47:0] dst = 48'h001122334455;
   logic [47:0] src = 48'h66778899AABB;
   logic [15:0] etype = 16'h0800;
   logic [63:0] pkt_tx_data;
   logic        pkt_tx_sop, pkt_tx_eop, pkt_tx_val, busy, done;
   logic [2:0]  pkt_tx_mod;
   logic [31:0] frames_sent;

   eth_tx_pkt_gen #(.LEN_W(14), .CNT_W(32)) dut (
      .clk_156(clk), .async_reset(rst), .start(start), .stop(stop),
      .frame_len(frame_len), .frame_cnt(frame_cnt), .ifg_cycles(ifg_cycles),
      .dst_mac(dst), .src_mac(src), .ethertype(etype), .pkt_tx_full(full),
      .pkt_tx_data(pkt_tx_data), .pkt_tx_sop(pkt_tx_sop), .pkt_tx_eop(pkt_tx_eop),
      .pkt_tx_val(pkt_tx_val), .pkt_tx_mod(pkt_tx_mod), .busy(busy), .done(done),
      .frames_sent(frames_sent));

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] d;
      logic        sop;
      logic        eop;
      logic [2:0]  mod;
      int          nvalid;
   } exp_t;

   exp_t expq[$];
   int   n_cmp = 0, n_err = 0;
   int   cyc = 0;
   int   n_val = 0, n_sop = 0, n_eop = 0, n_done = 0;
   int   last_eop_cyc = 0, done_cyc = 0;
   int   sop_cyc[$], eop_cyc[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Model: lay the frame out as a byte stream, then pack 8 bytes per word
   task automatic model_frame(input int len, input int seq);
      logic [7:0]  b[$];
      logic [7:0]  v;
      logic [63:0] d;
      exp_t        e;
      int          lc, words;
      lc = (len < 60) ? 60 : len;
      for (int i = 0; i < lc; i++) begin
         if (i < 6)        v = dst[8*(5-i) +: 8];
         else if (i < 12)  v = src[8*(11-i) +: 8];
         else if (i == 12) v = etype[15:8];
         else if (i == 13) v = etype[7:0];
         else if (i == 14) v = seq[15:8];
         else if (i == 15) v = seq[7:0];
         else              v = 8'((i - 16) % 256);
         b.push_back(v);
      end
      words = (lc + 7) / 8;
      for (int w = 0; w < words; w++) begin
         d = '0;
         for (int j = 0; j < 8; j++) d = {d[55:0], (w*8+j < lc) ? b[w*8+j] : 8'h00};
         e.d      = d;
         e.sop    = (w == 0);
         e.eop    = (w == words - 1);
         e.mod    = e.eop ? 3'(lc % 8) : 3'd0;
         e.nvalid = (e.eop && (lc % 8 != 0)) ? lc % 8 : 8;
         expq.push_back(e);
      end
   endtask

   always @(posedge clk) cyc++;

   // Compare process: every issued word against the model queue
   always @(negedge clk) begin
      exp_t        e;
      logic [63:0] m;
      if (!rst) begin
         if (pkt_tx_val) begin
            n_val++;
            if (pkt_tx_sop) begin n_sop++; sop_cyc.push_back(cyc); end
            if (pkt_tx_eop) begin n_eop++; eop_cyc.push_back(cyc); last_eop_cyc = cyc; end
            if (expq.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL unexpected_word: got %h expected no word", pkt_tx_data);
            end else begin
               e = expq.pop_front();
               m = ~64'h0 << (8 * (8 - e.nvalid));
               chk("word_data", pkt_tx_data & m, e.d & m);
               chk("word_sop", 64'(pkt_tx_sop), 64'(e.sop));
               chk("word_eop", 64'(pkt_tx_eop), 64'(e.eop));
               if (e.eop) chk("word_mod", 64'(pkt_tx_mod), 64'(e.mod));
            end
         end
         if (done) begin
            n_done++;
            done_cyc = cyc;
            chk("busy_low_with_done", 64'(busy), 64'd0);
         end
      end
   end

   task automatic start_run(input int len, input int cnt, input int ifg, input bit with_stop);
      @(negedge clk);
      frame_len = 14'(len); frame_cnt = cnt; ifg_cycles = 8'(ifg);
      start = 1'b1; stop = with_stop;
      @(negedge clk);
      start = 1'b0; stop = 1'b0;
   endtask

   task automatic wait_done(input string name, output int dcyc);
      bit seen;
      seen = 0;
      dcyc = -1;
      for (int i = 0; i < 3000 && !seen; i++) begin
         @(negedge clk);
         if (done) begin seen = 1; dcyc = cyc; end
      end
      if (!seen) begin
         n_cmp++; n_err++;
         $display("FAIL %s_timeout: got no done expected done within 3000 cycles", name);
      end
      @(negedge clk);
   endtask

   task automatic wait_sop(input int nth);
      int k;
      k = 0;
      for (int i = 0; i < 3000 && k < nth; i++) begin
         @(negedge clk);
         if (pkt_tx_val && pkt_tx_sop) k++;
      end
      if (k < nth) begin
         n_cmp++; n_err++;
         $display("FAIL sop_timeout: got %0d sops expected %0d", k, nth);
      end
   endtask

   task automatic chk_idle_outputs(input string name);
      chk({name, "_data"}, pkt_tx_data, 64'd0);
      chk({name, "_ctl"}, {55'd0, pkt_tx_sop, pkt_tx_eop, pkt_tx_val, pkt_tx_mod, busy, done}, 64'd0);
      chk({name, "_frames_sent"}, 64'(frames_sent), 64'd0);
   endtask

   initial begin
      int v0, s0, e0, d0, dc, sc;
      // Reset state
      repeat (3) @(negedge clk);
      chk_idle_outputs("reset");
      #2 rst = 1'b0;

      // L=64, one frame, no gap; model pinned with hand-computed words
      model_frame(64, 0);
      chk("model_words_64", 64'(expq.size()), 64'd8);
      chk("model_word0", expq[0].d, 64'h0011223344556677);
      chk("model_word1", expq[1].d, 64'h8899AABB08000000);
      chk("model_word2", expq[2].d, 64'h0001020304050607);
      chk("model_word7", expq[7].d, 64'h28292A2B2C2D2E2F);
      v0 = n_val; d0 = n_done;
      start_run(64, 1, 0, 0);
      chk("busy_after_start", 64'(busy), 64'd1);
      chk("no_word_at_start_edge", 64'(pkt_tx_val), 64'd0);
      @(negedge clk);
      chk("word0_latency", {62'd0, pkt_tx_val, pkt_tx_sop}, 64'd3);
      wait_done("l64", dc);
      chk("l64_done_after_eop", 64'(dc - last_eop_cyc), 64'd1);
      chk("l64_words", 64'(n_val - v0), 64'd8);
      chk("l64_done_pulses", 64'(n_done - d0), 64'd1);
      chk("l64_frames_sent", 64'(frames_sent), 64'd1);
      chk("l64_busy_cleared", 64'(busy), 64'd0);
      chk("l64_queue_drained", 64'(expq.size()), 64'd0);

      // L=65 and L=40 (clamped)
      model_frame(65, 0);
      chk("model_words_65", 64'(expq.size()), 64'd9);
      chk("model_mod_65", 64'(expq[8].mod), 64'd1);
      v0 = n_val;
      start_run(65, 1, 0, 0);
      wait_done("l65", dc);
      chk("l65_words", 64'(n_val - v0), 64'd9);
      model_frame(40, 0);
      chk("model_words_40", 64'(expq.size()), 64'd8);
      chk("model_mod_40", 64'(expq[7].mod), 64'd4);
      v0 = n_val;
      start_run(40, 1, 0, 0);
      wait_done("l40", dc);
      chk("l40_words", 64'(n_val - v0), 64'd8);

      // Backpressure for 3 cycles at word4
      model_frame(64, 0);
      v0 = n_val; s0 = n_sop; e0 = n_eop;
      start_run(64, 1, 0, 0);
      repeat (4) @(negedge clk);
      full = 1'b1;
      repeat (3) @(negedge clk);
      full = 1'b0;
      wait_done("bp", dc);
      chk("bp_words", 64'(n_val - v0), 64'd8);
      chk("bp_sops", 64'(n_sop - s0), 64'd1);
      chk("bp_eops", 64'(n_eop - e0), 64'd1);
      chk("bp_span", 64'(eop_cyc[$] - sop_cyc[$] + 1), 64'd11);

      // Three frames with 5-cycle gap
      for (int f = 0; f < 3; f++) model_frame(64, f);
      d0 = n_done; sc = sop_cyc.size();
      start_run(64, 3, 5, 0);
      wait_done("ifg", dc);
      chk("ifg_gap0", 64'(sop_cyc[sc+1] - eop_cyc[sc] - 1), 64'd5);
      chk("ifg_gap1", 64'(sop_cyc[sc+2] - eop_cyc[sc+1] - 1), 64'd5);
      chk("ifg_frames_sent", 64'(frames_sent), 64'd3);
      chk("ifg_done_pulses", 64'(n_done - d0), 64'd1);
      chk("ifg_queue_drained", 64'(expq.size()), 64'd0);

      // Continuous run stopped mid-frame 2
      for (int f = 0; f < 3; f++) model_frame(64, f);
      start_run(64, 0, 2, 0);
      wait_sop(3);
      repeat (2) @(negedge clk);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      wait_done("cont", dc);
      chk("cont_done_after_eop", 64'(dc - last_eop_cyc), 64'd1);
      chk("cont_frames_sent", 64'(frames_sent), 64'd3);
      v0 = n_val;
      repeat (20) @(negedge clk);
      chk("cont_no_frame3", 64'(n_val - v0), 64'd0);

      // Stop while in the gap
      model_frame(64, 0);
      start_run(64, 0, 10, 0);
      wait_sop(1);
      repeat (8) @(negedge clk);
      stop = 1'b1;
      e0 = cyc;
      @(negedge clk);
      stop = 1'b0;
      wait_done("gapstop", dc);
      chk("gapstop_done_latency", 64'(dc - e0), 64'd2);
      chk("gapstop_frames_sent", 64'(frames_sent), 64'd1);

      // Start and stop together: exactly one frame
      model_frame(64, 0);
      v0 = n_val;
      start_run(64, 0, 0, 1);
      wait_done("startstop", dc);
      chk("startstop_words", 64'(n_val - v0), 64'd8);
      chk("startstop_frames_sent", 64'(frames_sent), 64'd1);

      // Asynchronous reset at word3, then a clean frame with seq 0
      model_frame(64, 0);
      start_run(64, 2, 0, 0);
      repeat (4) @(negedge clk);
      #1 rst = 1'b1;
      #1 chk_idle_outputs("async_reset");
      expq.delete();
      @(negedge clk);
      #2 rst = 1'b0;
      model_frame(64, 0);
      v0 = n_val;
      start_run(100, 1, 0, 0);
      expq.delete();
      model_frame(100, 0);
      wait_done("after_reset", dc);
      chk("after_reset_words", 64'(n_val - v0), 64'd13);
      chk("after_reset_frames_sent", 64'(frames_sent), 64'd1);
      chk("after_reset_queue_drained", 64'(expq.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/eth_tx_pkt_gen.md
# eth_tx_pkt_gen

Test-traffic transmitter for the 10GE tester. It builds Ethernet frames (header, sequence number, generated payload) and writes them into the `xge_mac` transmit packet interface (`pkt_tx_*`), honouring `pkt_tx_full` backpressure. It is the source end of the packet path whose sink is the MAC/PCS receive wrapper. The MAC then appends the FCS and sends the frames through PCS to the PHY.

## Interface
Parameters:
- `LEN_W`, default 14: width of `frame_len`.
- `CNT_W`, default 32: width of `frame_cnt` and `frames_sent`.

Ports:
- `clk_156` in 1: 156.25 MHz system clock; all logic is in this domain.
- `async_reset` in 1: asynchronous reset, active-high.
- `start` in 1: one-cycle pulse that starts a run. Ignored while `busy`=1.
- `stop` in 1: pulse that ends a run after the current frame completes.
- `frame_len` in LEN_W: frame length in bytes, excluding FCS. Sampled at `start`. Values below 60 are clamped to 60.
- `frame_cnt` in CNT_W: number of frames in the run. 0 means continuous until `stop`.
- `ifg_cycles` in 8: number of idle cycles between frames (0 is allowed).
- `dst_mac` in 48, `src_mac` in 48, `ethertype` in 16: header fields, sampled at `start`.
- `pkt_tx_full` in 1: MAC TX FIFO almost-full.
- `pkt_tx_data` out 64: data word; byte 0 is bits [63:56].
- `pkt_tx_sop`, `pkt_tx_eop`, `pkt_tx_val` out 1 each.
- `pkt_tx_mod` out 3: valid bytes in the EOP word; 0 means 8.
- `busy` out 1: a run is in progress.
- `done` out 1: one-cycle pulse when a run ends.
- `frames_sent` out CNT_W: frames completed since the last `start`.

## Operation
- Frame word layout:
  - word0: `dst_mac[47:0]`, then `src_mac[47:32]`.
  - word1: `src_mac[31:0]`, `ethertype`, `seq[15:0]`, where `seq` = `frames_sent[15:0]` at SOP.
  - word2 onward: payload.
- Frame size: words = ceil(L/8); `mod` = L mod 8. `sop` is on word0 and `eop` is on the last word. When L ≤ 16, payload bytes are truncated as needed.
- The payload generator reseeds at every SOP, so every frame carries identical payload.
- FSM states:
  - IDLE → SEND on `start`. At this transition, latch the run inputs, clear `frames_sent`, and set `busy`.
  - SEND: emits one word per cycle in which `pkt_tx_full` was sampled low. After the EOP word, `frames_sent` increments, then:
    - → DONE if `stop` is pending or the count is reached (`frame_cnt`≠0 and `frames_sent`+1 = `frame_cnt`);
    - → GAP if `ifg_cycles`>0;
    - otherwise → SEND, starting the next frame on the following cycle.
  - GAP: counts `ifg_cycles` cycles with `pkt_tx_val`=0, then → SEND. A `stop` in GAP goes directly → DONE.
  - DONE: pulses `done` for one cycle, clears `busy`, → IDLE.
- `stop` is latched as pending. A frame is never truncated.
- `start` and `stop` in the same IDLE cycle: the run starts and ends after exactly one frame.
- Backpressure: while `pkt_tx_full`=1, `val`=0 and the word pointer holds. SOP/EOP flags are never repeated or dropped.
- `frames_sent` wraps modulo 2^CNT_W in continuous mode.
- Asserting `async_reset` at any time, including mid-frame, immediately forces every output to 0 and the FSM to IDLE. No partial-frame recovery is attempted.

## Timing
- Reset values: all outputs are 0.
- `start` sampled at edge k → word0 (`sop`=1, `val`=1) is on the outputs after edge k+1.
- All outputs are registered. A word is issued at edge k only if `pkt_tx_full`=0 at edge k. The one-cycle reaction latency is absorbed by the MAC FIFO almost-full margin.
- With no backpressure, a frame of W words occupies exactly W consecutive `val` cycles. Between frames there are exactly `ifg_cycles` `val`=0 cycles.
- `done` is asserted the cycle after the final EOP word, or the cycle after `stop` is sampled in GAP. `busy` falls in the same cycle that `done` rises.

## Configuration
- `ETH_TX_PKT_GEN_PRBS_EN` defined: payload is PRBS31 (x^31+x^28+1), seeded with all-ones at each SOP, advancing 64 bits per word, MSB first.
- `ETH_TX_PKT_GEN_PRBS_EN` undefined: payload is an incrementing byte pattern. Payload byte n has value (n mod 256), where n counts from 0 at the first byte of word2. No LFSR is present.

## Test plan
- L=64, `frame_cnt`=1, `ifg_cycles`=0:
  - 8 words with `val`=1;
  - word0 has `sop`;
  - word7 has `eop` and `mod`=0;
  - word1[15:0]=0x0000;
  - `done` the cycle after word7; `frames_sent`=1.
- L=65: 9 words, `eop` word has `mod`=1; L=40 (clamped to 60): 8 words, `mod`=4.
- L=64 with `pkt_tx_full` high for 3 cycles at word4: `val` low for exactly 3 cycles; words 4–7 are delivered intact and in order; exactly one `sop` and one `eop`.
- `frame_cnt`=3, `ifg_cycles`=5: exactly 5 idle cycles between frames; seq fields 0, 1, 2; `frames_sent`=3; one `done` pulse.
- `frame_cnt`=0 with `stop` in mid-frame 2: frame 2 completes, no frame 3 starts, `frames_sent`=3 (frames 0–2). `stop` during GAP: `done` the next cycle.
- `async_reset` asserted at word3: all outputs are 0 within the same cycle. A new `start` then produces a clean frame with seq=0.
